mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 187 ++++++++++++++++++
 tb/tb_mem_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Dual-port memory responder: independent instruction and data ports with a fixed
// response latency, byte-enabled data writes and a sticky protocol/address error flag.

module mem_responder_port #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [31:0] cap_data_i,
    output logic        capture_o,
    output logic        resp_o,
    output logic        busy_o,
    output logic [31:0] rdata_o
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] rdata_q, rdata_d;

    // Handshake: a request is captured on an edge where req_i is high and the port
    // is either IDLE or presenting its response (resp_o high) in that same cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        rdata_d   = rdata_q;
        capture_o = 1'b0;
        resp_o    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    capture_o = 1'b1;
                    state_d   = S_WAIT;
                    cnt_d     = CNT_LOAD;
                    pend_d    = cap_data_i;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    resp_o = 1'b1;
                    if (req_i) begin
                        capture_o = 1'b1;
                        cnt_d     = CNT_LOAD;
                        pend_d    = cap_data_i;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // rdata only moves on the edge that enters a response cycle, so it holds in between.
        if (state_d == S_WAIT && cnt_d == 4'd0) begin
            rdata_d = capture_o ? cap_data_i : pend_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            pend_q  <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            rdata_q <= rdata_d;
        end
    end

    assign busy_o  = (state_q == S_WAIT);
    assign rdata_o = rdata_q;
endmodule

module mem_responder #(
    parameter int          LATENCY     = 2,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h1eceb000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0] i_off, d_off;
    logic        i_ok, d_ok;
    logic [AW-1:0] i_idx, d_idx;
    logic        i_req, d_req, d_rd, d_wr;
    logic [31:0] i_cap_data, d_cap_data;
    logic        i_cap, d_cap, i_busy, d_busy;
    logic        d_we;
    logic        err_q, err_d;

    // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
    assign i_off = imem_addr - BASE_ADDR;
    assign d_off = dmem_addr - BASE_ADDR;
    assign i_ok  = ((i_off >> 2) < 32'(DEPTH_WORDS)) && (imem_addr[1:0] == 2'b00);
    assign d_ok  = ((d_off >> 2) < 32'(DEPTH_WORDS)) && (dmem_addr[1:0] == 2'b00);
    assign i_idx = i_off[AW+1:2];
    assign d_idx = d_off[AW+1:2];

    assign d_rd  = |dmem_rmask;
    assign d_wr  = |dmem_wmask;
    assign i_req = (|imem_rmask) & ~rst;
    assign d_req = (d_rd | d_wr) & ~rst;

    // Reads sample the array before this edge's write lands, giving pre-write data.
    assign i_cap_data = i_ok ? mem_q[i_idx] : 32'h0;
    assign d_cap_data = (d_ok && d_rd) ? mem_q[d_idx] : 32'h0;

    mem_responder_port #(.LATENCY(LATENCY)) u_imem_port (
        .clk        (clk),
        .rst        (rst),
        .req_i      (i_req),
        .cap_data_i (i_cap_data),
        .capture_o  (i_cap),
        .resp_o     (imem_resp),
        .busy_o     (i_busy),
        .rdata_o    (imem_rdata)
    );

    mem_responder_port #(.LATENCY(LATENCY)) u_dmem_port (
        .clk        (clk),
        .rst        (rst),
        .req_i      (d_req),
        .cap_data_i (d_cap_data),
        .capture_o  (d_cap),
        .resp_o     (dmem_resp),
        .busy_o     (d_busy),
        .rdata_o    (dmem_rdata)
    );

    assign d_we = d_cap & d_ok & d_wr;

    always_ff @(posedge clk) begin
        if (d_we) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_wmask[b]) begin
                    mem_q[d_idx][8*b +: 8] <= dmem_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        err_d = err_q;
        if (i_cap && !i_ok) err_d = 1'b1;
        if (d_cap && (!d_ok || (d_rd && d_wr))) err_d = 1'b1;
        // A request arriving while still counting down is dropped.
        if (i_req && i_busy && !imem_resp) err_d = 1'b1;
        if (d_req && d_busy && !dmem_resp) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 1, 2, 3) driven one at a time,
// with per-port expected queues checked by negedge monitors.

module tb_mem_responder;
    localparam logic [31:0] BASE  = 32'h1eceb000;
    localparam int          DEPTH = 1024;

    typedef struct {
        int          inst;
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr  [3];
    logic [3:0]  imem_rmask [3];
    logic [31:0] imem_rdata [3];
    logic        imem_resp  [3];
    logic [31:0] dmem_addr  [3];
    logic [3:0]  dmem_rmask [3];
    logic [3:0]  dmem_wmask [3];
    logic [31:0] dmem_wdata [3];
    logic [31:0] dmem_rdata [3];
    logic        dmem_resp  [3];
    logic        err        [3];

    exp_t iexp_q[$];
    exp_t dexp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic rst_seen = 1'b1;

    // clock/reset
    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp_v);
        end
    endtask

    task automatic mon(input int inst, input int port, input logic resp, input logic [31:0] rdata,
                       input logic [31:0] last, output logic [31:0] last_n);
        exp_t  e;
        bit    has;
        string pn;
        pn     = (port == 0) ? "imem" : "dmem";
        has    = 1'b0;
        last_n = last;
        if (resp === 1'b1) begin
            if (port == 0 && iexp_q.size() > 0) begin
                e = iexp_q.pop_front(); has = 1'b1;
            end else if (port == 1 && dexp_q.size() > 0) begin
                e = dexp_q.pop_front(); has = 1'b1;
            end
            if (!has) begin
                n_vec++; n_err++;
                $display("FAIL inst%0d_%s_unexpected_resp: got resp at cycle %0d rdata %h, required no resp",
                         inst, pn, cyc, rdata);
            end else begin
                chk($sformatf("inst%0d_%s_resp_inst", inst, pn), 32'(inst), 32'(e.inst));
                chk($sformatf("inst%0d_%s_resp_cycle", inst, pn), 32'(cyc), 32'(e.cyc));
                chk($sformatf("inst%0d_%s_rdata", inst, pn), rdata, e.data);
            end
            last_n = rdata;
        end else if (rst_seen) begin
            last_n = rdata;
        end else begin
            chk($sformatf("inst%0d_%s_rdata_hold", inst, pn), rdata, last);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_responder #(
            .LATENCY     (g + 1),
            .DEPTH_WORDS (DEPTH),
            .BASE_ADDR   (BASE)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .imem_addr  (imem_addr[g]),
            .imem_rmask (imem_rmask[g]),
            .imem_rdata (imem_rdata[g]),
            .imem_resp  (imem_resp[g]),
            .dmem_addr  (dmem_addr[g]),
            .dmem_rmask (dmem_rmask[g]),
            .dmem_wmask (dmem_wmask[g]),
            .dmem_wdata (dmem_wdata[g]),
            .dmem_rdata (dmem_rdata[g]),
            .dmem_resp  (dmem_resp[g]),
            .err        (err[g])
        );

        logic [31:0] i_last = 32'h0;
        logic [31:0] d_last = 32'h0;
        always @(negedge clk) begin
            mon(g, 0, imem_resp[g], imem_rdata[g], i_last, i_last);
            mon(g, 1, dmem_resp[g], dmem_rdata[g], d_last, d_last);
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            imem_rmask[k] = 4'h0;
            dmem_rmask[k] = 4'h0;
            dmem_wmask[k] = 4'h0;
        end
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_rst();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic iread(input int k, input logic [31:0] a, input logic [31:0] exp_d, input bit want);
        exp_t e;
        imem_addr[k]  = a;
        imem_rmask[k] = 4'hF;
        if (want) begin
            e.inst = k; e.cyc = cyc + k + 1; e.data = exp_d;
            iexp_q.push_back(e);
        end
    endtask

    task automatic dreq(input int k, input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                        input logic [31:0] wd, input logic [31:0] exp_d, input bit want);
        exp_t e;
        dmem_addr[k]  = a;
        dmem_rmask[k] = rm;
        dmem_wmask[k] = wm;
        dmem_wdata[k] = wd;
        if (want) begin
            e.inst = k; e.cyc = cyc + k + 1; e.data = exp_d;
            dexp_q.push_back(e);
        end
    endtask

    initial begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            imem_addr[k] = 32'h0; imem_rmask[k] = 4'h0;
            dmem_addr[k] = 32'h0; dmem_rmask[k] = 4'h0;
            dmem_wmask[k] = 4'h0; dmem_wdata[k] = 32'h0;
        end
        rst = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("inst%0d_reset_imem_resp", k), 32'(imem_resp[k]), 32'h0);
            chk($sformatf("inst%0d_reset_dmem_resp", k), 32'(dmem_resp[k]), 32'h0);
            chk($sformatf("inst%0d_reset_imem_rdata", k), imem_rdata[k], 32'h0);
            chk($sformatf("inst%0d_reset_dmem_rdata", k), dmem_rdata[k], 32'h0);
            chk($sformatf("inst%0d_reset_err", k), 32'(err[k]), 32'h0);
        end
        rst = 1'b0;

        // LATENCY=2: write then delayed instruction read, byte-enable merge
        tick(); dreq(1, BASE + 32'h10, 4'h0, 4'hF, 32'hDEADBEEF, 32'h0, 1'b1);
        tick(); tick();
        tick(); iread(1, BASE + 32'h10, 32'hDEADBEEF, 1'b1);
        drain(3);
        tick(); dreq(1, BASE + 32'h10, 4'h0, 4'b0010, 32'h0000AA00, 32'h0, 1'b1); drain(3);
        tick(); dreq(1, BASE + 32'h10, 4'b0001, 4'h0, 32'h0, 32'hDEADAAEF, 1'b1); drain(3);
        chk("err_clean_traffic", 32'(err[1]), 32'h0);

        // same-edge imem read and dmem write of one word
        tick(); dreq(1, BASE + 32'h14, 4'h0, 4'hF, 32'h11111111, 32'h0, 1'b1); drain(3);
        tick(); iread(1, BASE + 32'h14, 32'h11111111, 1'b1);
        dreq(1, BASE + 32'h14, 4'h0, 4'hF, 32'h22222222, 32'h0, 1'b1); drain(3);
        tick(); iread(1, BASE + 32'h14, 32'h22222222, 1'b1); drain(3);
        chk("err_same_edge", 32'(err[1]), 32'h0);

        // dmem read+write in one request
        tick(); dreq(1, BASE + 32'h18, 4'h0, 4'hF, 32'h33333333, 32'h0, 1'b1); drain(3);
        tick(); dreq(1, BASE + 32'h18, 4'hF, 4'b1000, 32'h44000000, 32'h33333333, 1'b1); drain(3);
        chk("err_rw_conflict", 32'(err[1]), 32'h1);
        tick(); dreq(1, BASE + 32'h18, 4'hF, 4'h0, 32'h0, 32'h44333333, 1'b1); drain(3);
        pulse_rst();
        chk("err_cleared_by_rst_1", 32'(err[1]), 32'h0);

        // misaligned and out-of-range accesses
        tick(); dreq(1, BASE, 4'h0, 4'hF, 32'h0BADF00D, 32'h0, 1'b1); drain(3);
        chk("err_before_bad_addr", 32'(err[1]), 32'h0);
        tick(); dreq(1, BASE + 32'h2, 4'hF, 4'h0, 32'h0, 32'h0, 1'b1); drain(3);
        chk("err_misaligned", 32'(err[1]), 32'h1);
        tick(); dreq(1, BASE + 32'h12, 4'h0, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1); drain(3);
        tick(); dreq(1, BASE + 32'(4 * DEPTH), 4'h0, 4'hF, 32'h12345678, 32'h0, 1'b1); drain(3);
        tick(); iread(1, BASE + 32'(4 * DEPTH), 32'h0, 1'b1); drain(3);
        tick(); iread(1, BASE + 32'h2, 32'h0, 1'b1); drain(3);
        tick(); iread(1, BASE - 32'h4, 32'h0, 1'b1);
        dreq(1, BASE, 4'hF, 4'h0, 32'h0, 32'h0BADF00D, 1'b1); drain(3);
        tick(); iread(1, BASE + 32'h10, 32'hDEADAAEF, 1'b1); drain(3);
        pulse_rst();
        chk("err_cleared_by_rst_2", 32'(err[1]), 32'h0);

        // LATENCY=1: back-to-back writes then back-to-back reads
        for (int i = 0; i < 8; i++) begin
            tick(); dreq(0, BASE + 32'h100 + 32'(4 * i), 4'h0, 4'hF, 32'hC0DE0000 + 32'(i), 32'h0, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            tick(); iread(0, BASE + 32'h100 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 1'b1);
        end
        drain(3);
        chk("err_lat1_stream", 32'(err[0]), 32'h0);

        // LATENCY=3: request during countdown is ignored
        tick(); dreq(2, BASE + 32'h20, 4'h0, 4'hF, 32'h5555AAAA, 32'h0, 1'b1); drain(4);
        tick(); dreq(2, BASE + 32'h20, 4'hF, 4'h0, 32'h0, 32'h5555AAAA, 1'b1);
        tick(); dreq(2, BASE + 32'h20, 4'h0, 4'hF, 32'hFFFF0000, 32'h0, 1'b0);
        drain(4);
        chk("err_busy_ignore", 32'(err[2]), 32'h1);
        tick(); dreq(2, BASE + 32'h20, 4'hF, 4'h0, 32'h0, 32'h5555AAAA, 1'b1); drain(4);
        pulse_rst();
        chk("err_cleared_by_rst_3", 32'(err[2]), 32'h0);

        // reset right after capture drops the response, keeps the write
        tick(); dreq(2, BASE + 32'h24, 4'h0, 4'hF, 32'h77777777, 32'h0, 1'b0);
        iread(2, BASE + 32'h20, 32'h0, 1'b0);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        drain(5);
        tick(); dreq(2, BASE + 32'h24, 4'hF, 4'h0, 32'h0, 32'h77777777, 1'b1); drain(4);

        // request during reset is neither captured nor written
        tick(); dreq(2, BASE + 32'h28, 4'h0, 4'hF, 32'h12121212, 32'h0, 1'b1); drain(4);
        tick(); rst = 1'b1; dreq(2, BASE + 32'h28, 4'h0, 4'hF, 32'h99999999, 32'h0, 1'b0);
        tick(); rst = 1'b0;
        drain(4);
        tick(); dreq(2, BASE + 32'h28, 4'hF, 4'h0, 32'h0, 32'h12121212, 1'b1); drain(4);
        chk("err_after_rst_traffic", 32'(err[2]), 32'h0);

        drain(10);
        while (iexp_q.size() > 0) begin
            e = iexp_q.pop_front();
            n_vec++; n_err++;
            $display("FAIL inst%0d_imem_missing_resp: got no resp, required resp at cycle %0d rdata %h",
                     e.inst, e.cyc, e.data);
        end
        while (dexp_q.size() > 0) begin
            e = dexp_q.pop_front();
            n_vec++; n_err++;
            $display("FAIL inst%0d_dmem_missing_resp: got no resp, required resp at cycle %0d rdata %h",
                     e.inst, e.cyc, e.data);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
